// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, sync/blank decode delayed to match the
// object pipeline, and RRRGGGBB colour expansion gated by the delayed visible flag.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIPE_DLY = 1
) (
   input  logic        CLK,
   input  logic        RESETn,
   input  logic [7:0]  iRGB,
   output logic [10:0] oCoord_X,
   output logic [10:0] oCoord_Y,
   output logic        oFrameStart,
   output logic        oVGA_HS,
   output logic        oVGA_VS,
   output logic        oVGA_BLANK_N,
   output logic [7:0]  oVGA_R,
   output logic [7:0]  oVGA_G,
   output logic [7:0]  oVGA_B
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] HLast     = 11'(H_TOTAL - 1);
   localparam logic [10:0] VLast     = 11'(V_TOTAL - 1);
   localparam logic [10:0] HAct      = 11'(H_ACTIVE);
   localparam logic [10:0] VAct      = 11'(V_ACTIVE);
   localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);

   if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : gen_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 11-bit counter range");
   end
   if (PIPE_DLY > 4) begin : gen_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be 0..4");
   end

   logic [10:0] h_q, h_d, v_q, v_d;
   logic        h_wrap, v_wrap;
   logic        frame_start_q;

   always_comb begin
      h_wrap = (h_q == HLast);
      v_wrap = (v_q == VLast);
      h_d    = h_wrap ? 11'd0 : h_q + 11'd1;
      v_d    = v_q;
      if (h_wrap) begin
         v_d = v_wrap ? 11'd0 : v_q + 11'd1;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         h_q           <= '0;
         v_q           <= '0;
         frame_start_q <= 1'b0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         frame_start_q <= h_wrap && v_wrap;
      end
   end

   logic hs_raw, vs_raw, act_raw;

   always_comb begin
      act_raw = (h_q < HAct) && (v_q < VAct);
      hs_raw  = !((h_q >= HSyncBeg) && (h_q < HSyncEnd));
      vs_raw  = !((v_q >= VSyncBeg) && (v_q < VSyncEnd));
   end

   // Bit 0 of each chain is the raw decode; bit i+1 is delay stage i.
   logic [PIPE_DLY:0]   hs_pipe_q, vs_pipe_q, act_pipe_q;
   logic [PIPE_DLY+1:0] hs_chain, vs_chain, act_chain;
   logic                act_gate;
   logic [23:0]         rgb_d, rgb_q;

   always_comb begin
      hs_chain  = {hs_pipe_q, hs_raw};
      vs_chain  = {vs_pipe_q, vs_raw};
      act_chain = {act_pipe_q, act_raw};
      // Visible flag that lands on the pins together with the colour being sampled now.
      act_gate  = act_chain[PIPE_DLY];
      rgb_d     = '0;
      if (act_gate) begin
         rgb_d = {iRGB[7:5], iRGB[7:5], iRGB[7:6],
                  iRGB[4:2], iRGB[4:2], iRGB[4:3],
                  {4{iRGB[1:0]}}};
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         hs_pipe_q  <= '1;
         vs_pipe_q  <= '1;
         act_pipe_q <= '0;
         rgb_q      <= '0;
      end else begin
         hs_pipe_q  <= hs_chain[PIPE_DLY:0];
         vs_pipe_q  <= vs_chain[PIPE_DLY:0];
         act_pipe_q <= act_chain[PIPE_DLY:0];
         rgb_q      <= rgb_d;
      end
   end

   assign oCoord_X     = h_q;
   assign oCoord_Y     = v_q;
   assign oFrameStart  = frame_start_q;
   assign oVGA_HS      = hs_pipe_q[PIPE_DLY];
   assign oVGA_VS      = vs_pipe_q[PIPE_DLY];
   assign oVGA_BLANK_N = act_pipe_q[PIPE_DLY];
   assign oVGA_R       = rgb_q[23:16];
   assign oVGA_G       = rgb_q[15:8];
   assign oVGA_B       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two reduced-raster instances (PIPE_DLY 1 and 3) checked
// cycle by cycle against a scoreboard, plus a full 640x480 instance for line timing.
module tb_vga_timing_gen;

   localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
   localparam int VA = 6,  VF = 1, VSY = 2, VB = 1;
   localparam int HT = HA + HF + HSY + HB;
   localparam int VT = VA + VF + VSY + VB;
   localparam int TX = 9, TY = 4;

   typedef struct {
      int         h;
      int         v;
      logic       hs;
      logic       vs;
      logic       bl;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_asserts = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_asserts++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] expand(input logic [7:0] c);
      return {c[7:5], c[7:5], c[7:6], c[4:2], c[4:2], c[4:3], {4{c[1:0]}}};
   endfunction

   function automatic logic is_active(input int h, input int v);
      return (h < HA) && (v < VA);
   endfunction

   function automatic logic [7:0] pick(input int h, input int v);
      if (h == TX && v == TY)     return 8'hE0;
      if (h == TX + 1 && v == TY) return 8'h93;
      if (is_active(h, v))        return 8'($urandom);
      return 8'hFF;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      localparam int D = (g == 0) ? 1 : 3;
      logic [10:0] x, y;
      logic        hs, vs, bl, fs;
      logic [7:0]  r, gr, b;
      logic [7:0]  rgb_in = 8'hFF;
      exp_t        exp_q[$];
      logic [7:0]  drv_q[$];
      int          mh = 0, mv = 0, hits = 0, lo_run = 0;
      bit          wrapped = 0, lo_valid = 0;
      string       pfx = (g == 0) ? "dly1_" : "dly3_";

      vga_timing_gen #(
         .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
         .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
         .PIPE_DLY(D)
      ) u_dut (
         .CLK(clk), .RESETn(rst_n), .iRGB(rgb_in),
         .oCoord_X(x), .oCoord_Y(y), .oFrameStart(fs),
         .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_N(bl),
         .oVGA_R(r), .oVGA_G(gr), .oVGA_B(b)
      );

      always @(negedge clk) begin : sb
         exp_t       it, e;
         logic [7:0] val;
         logic [23:0] c;
         if (!rst_n) begin
            check_eq({pfx, "rst_x"}, 32'(x), 0);
            check_eq({pfx, "rst_y"}, 32'(y), 0);
            check_eq({pfx, "rst_hs"}, 32'(hs), 1);
            check_eq({pfx, "rst_vs"}, 32'(vs), 1);
            check_eq({pfx, "rst_blank_n"}, 32'(bl), 0);
            check_eq({pfx, "rst_frame_start"}, 32'(fs), 0);
            check_eq({pfx, "rst_rgb"}, 32'({r, gr, b}), 0);
            mh = 0; mv = 0; wrapped = 0; lo_run = 0; lo_valid = 0;
            exp_q.delete();
            drv_q.delete();
            for (int i = 0; i <= D; i++)
               exp_q.push_back('{h: -1, v: -1, hs: 1, vs: 1, bl: 0, r: 0, g: 0, b: 0});
            for (int i = 0; i < D; i++) drv_q.push_back(8'hFF);
            rgb_in = 8'hFF;
         end else begin
            check_eq({pfx, "coord_x"}, 32'(x), 32'(mh));
            check_eq({pfx, "coord_y"}, 32'(y), 32'(mv));
            check_eq({pfx, "frame_start"}, 32'(fs), 32'(wrapped && mh == 0 && mv == 0));
            val   = pick(mh, mv);
            it.h  = mh;
            it.v  = mv;
            it.bl = is_active(mh, mv);
            it.hs = !(mh >= HA + HF && mh < HA + HF + HSY);
            it.vs = !(mv >= VA + VF && mv < VA + VF + VSY);
            c     = it.bl ? expand(val) : 24'h0;
            it.r  = c[23:16];
            it.g  = c[15:8];
            it.b  = c[7:0];
            exp_q.push_back(it);
            drv_q.push_back(val);
            e = exp_q.pop_front();
            check_eq({pfx, "hs"}, 32'(hs), 32'(e.hs));
            check_eq({pfx, "vs"}, 32'(vs), 32'(e.vs));
            check_eq({pfx, "blank_n"}, 32'(bl), 32'(e.bl));
            check_eq({pfx, "rgb"}, 32'({r, gr, b}), 32'({e.r, e.g, e.b}));
            if (e.h == TX && e.v == TY) begin
               hits++;
               check_eq({pfx, "obj_red"}, 32'({bl, r, gr, b}), 32'h1FF0000);
            end
            if (e.h == TX + 1 && e.v == TY)
               check_eq({pfx, "expand_93"}, 32'({r, gr, b}), 32'h9292FF);
            if (!vs) begin
               lo_run++;
            end else begin
               if (lo_valid && lo_run > 0) check_eq({pfx, "vs_low_clks"}, lo_run, VSY * HT);
               lo_run   = 0;
               lo_valid = 1;
            end
            rgb_in = drv_q.pop_front();
            if (mh == HT - 1) begin
               mh = 0;
               if (mv == VT - 1) begin
                  mv = 0;
                  wrapped = 1;
               end else begin
                  mv++;
               end
            end else begin
               mh++;
            end
         end
      end
   end

   // Full-size raster, default parameters, line timing only.
   logic [10:0] fx, fy;
   logic        fhs, fvs, fbl, ffs;
   logic [7:0]  fr, fg, fb;
   logic [7:0]  full_rgb = 8'hFF;

   vga_timing_gen u_full (
      .CLK(clk), .RESETn(rst_n), .iRGB(full_rgb),
      .oCoord_X(fx), .oCoord_Y(fy), .oFrameStart(ffs),
      .oVGA_HS(fhs), .oVGA_VS(fvs), .oVGA_BLANK_N(fbl),
      .oVGA_R(fr), .oVGA_G(fg), .oVGA_B(fb)
   );

   int cyc, t656, tfall, tx0, trise;
   logic hs_prev, bl_prev;

   always @(negedge clk) begin
      if (!rst_n) begin
         cyc = 0; t656 = -1; tfall = -1; tx0 = -1; trise = -1;
         hs_prev = 1'b1; bl_prev = 1'b0;
      end else begin
         cyc++;
         if (fx == 11'd656) t656 = cyc;
         if (fx == 11'd0) tx0 = cyc;
         if (hs_prev && !fhs) begin
            if (t656 >= 0) check_eq("full_hs_fall_ofs", cyc - t656, 2);
            if (tfall >= 0) check_eq("full_hs_period", cyc - tfall, 800);
            tfall = cyc;
         end
         if (!hs_prev && fhs && tfall >= 0) check_eq("full_hs_low", cyc - tfall, 96);
         if (!bl_prev && fbl) begin
            if (tx0 >= 0) check_eq("full_blank_rise_ofs", cyc - tx0, 2);
            trise = cyc;
         end
         if (bl_prev && !fbl && trise >= 0) check_eq("full_blank_high", cyc - trise, 640);
         if (!fbl) check_eq("full_blank_rgb", 32'({fr, fg, fb}), 0);
         hs_prev = fhs;
         bl_prev = fbl;
      end
   end

   initial begin
      bit found;
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (2000) @(posedge clk);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (gen_dut[0].x == 11'd11 && gen_dut[0].y == 11'd3) found = 1'b1;
      end
      check_eq("mid_reset_sync", 32'(found), 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (600) @(posedge clk);
      @(negedge clk);
      check_eq("dly1_target_seen", 32'(gen_dut[0].hits != 0), 1);
      check_eq("dly3_target_seen", 32'(gen_dut[1].hits != 0), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster pixel coordinates (oCoord_X/oCoord_Y) that every sprite/object block consumes.
- Receives back the final 8-bit RRRGGGBB colour selected by the object priority mux.
- Drives the physical VGA pins: HS, VS, BLANK_N and 8-bit R/G/B.
- Delays sync and blank to match the object pipeline latency, so colour and timing leave the chip aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, object-path latency in clocks from oCoord to iRGB valid; legal range 0..4

Ports:
- CLK  in  1  pixel clock (25.175 MHz nominal)
- RESETn  in  1  asynchronous active-low reset
- iRGB  in  8  final pixel colour RRRGGGBB from priority mux, valid PIPE_DLY clocks after its coordinate
- oCoord_X  out  11  current horizontal counter, 0..H_TOTAL-1
- oCoord_Y  out  11  current vertical counter, 0..V_TOTAL-1
- oFrameStart  out  1  one-clock pulse while coordinates equal (0,0)
- oVGA_HS  out  1  horizontal sync, active low
- oVGA_VS  out  1  vertical sync, active low
- oVGA_BLANK_N  out  1  high during visible pixels
- oVGA_R  out  8  red
- oVGA_G  out  8  green
- oVGA_B  out  8  blue

Behaviour:
- Clock and reset: CLK is the clock; RESETn is the reset, asynchronous, active-low.
- Totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be ≤ 2047; counters are 11-bit unsigned.
- Counters (registered, drive oCoord directly):
  - h increments every clock.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h wrap, v wraps to 0.
  - Coordinates run through blanking; objects are placed only in the visible area.
- Raw (undelayed) decodes, per coordinate:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs_n = !(h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)), i.e. low for h 656..751.
  - vs_n = !(v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)), i.e. low for v 490..491, over the full line.
- Alignment:
  - Raw hs_n/vs_n/active pass through a shift register of PIPE_DLY+1 stages.
  - Each output stage is registered.
  - Sync/blank for the coordinate presented at cycle n appear on the pins at cycle n+PIPE_DLY+1.
- Colour:
  - Output register samples iRGB each clock, so colour for the coordinate at cycle n appears at n+PIPE_DLY+1.
  - Expansion: R = {iRGB[7:5],iRGB[7:5],iRGB[7:6]}; G = {iRGB[4:2],iRGB[4:2],iRGB[4:3]}; B = {iRGB[1:0] repeated 4x}.
  - When the delayed active is 0, R/G/B register 0 regardless of iRGB.
- oFrameStart:
  - Register, set for exactly one clock on the edge where counters wrap (799,524)→(0,0); coincident with oCoord=(0,0).
  - Not asserted for the first frame after reset release.
- Reset values:
  - Counters 0, so oCoord = (0,0).
  - oFrameStart 0; oVGA_HS 1; oVGA_VS 1; oVGA_BLANK_N 0; RGB 0.
  - All delay-line stages take inactive values (hs_n=1, vs_n=1, active=0).
  - The coordinate (0,0) is held throughout reset; the first edge after release advances to (1,0).
- Reset mid-frame:
  - Immediate return to reset values; no partial sync pulse completes.
  - Timing restarts from (0,0).
- Simultaneous events:
  - h wrap and v wrap on the same edge are handled in one cycle.
  - The VS boundary changes exactly at h=0 of lines 490 and 492, not mid-line.
- No handshake or backpressure: the block free-runs. iRGB is sampled unconditionally; X/undriven iRGB during blanking must not reach the pins.

Test Plan:
- Reset/defaults: hold RESETn=0 for 5 clocks with iRGB=8'hFF → oCoord=(0,0), HS=VS=1, BLANK_N=0, RGB=0, oFrameStart=0; release → oCoord_X=1 after the first edge.
- Line timing, PIPE_DLY=1:
  - Measure HS: low for exactly 96 clocks, period 800.
  - HS falls 2 clocks after oCoord_X=656.
  - BLANK_N rises 2 clocks after oCoord_X=0 on line 0 and stays high 640 clocks.
- Frame timing:
  - VS low for exactly 1600 clocks (2 lines), frame period 420000 clocks.
  - oFrameStart pulses once per frame, only from the second frame after reset.
- Colour alignment and expansion:
  - Model a 1-cycle object driving iRGB=8'hE0 only when oCoord=(279,472) → oVGA_R=8'hFF, G=0, B=0 exactly 2 clocks later with BLANK_N=1.
  - iRGB=8'h93 → R=8'h92, G=8'h92, B=8'hFF.
- Blank gating: drive iRGB=8'hFF constantly → RGB=0 whenever BLANK_N=0 (e.g. coordinate (700,100) and all of line 500).
- Mid-frame reset and latency parameter:
  - Assert RESETn at (300,200) for 1 clock → outputs return to reset values asynchronously; the next line restarts at (0,0).
  - Repeat the alignment test with PIPE_DLY=3 → 4-clock offset.
